// File: rtl/nmcu_pkg.sv
// nmcu_pkg: shared constants and types for the NMCU PE array datapath.
//   PSUM_WIDTH / DATA_WIDTH : partial-sum and output element widths
//   PE_ROWS / PE_COLS       : PE array geometry
//   OUT_WIDTH               : default requantized element width
//   SHAMT_WIDTH             : width of a requant right-shift amount
//   drain_state_e           : result drain FSM states
package nmcu_pkg;

  localparam int unsigned PSUM_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned PE_ROWS     = 4;
  localparam int unsigned PE_COLS     = 4;
  localparam int unsigned OUT_WIDTH   = DATA_WIDTH;
  localparam int unsigned SHAMT_WIDTH = $clog2(PSUM_WIDTH);

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_BUSY
  } drain_state_e;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_result_drain_requant.sv
// pe_result_requant: combinational requantizer for one partial-sum element.
//   y = (x + round) >>> shamt, computed one bit wider than the input so the
//   rounding add never overflows, then saturated to the signed OUT_WIDTH range.
// Option macro: NMCU_RESULT_RELU_EN clamps negative shifted values to zero
// before saturation.
// Ports:
//   psum_i  [PSUM_WIDTH]  signed partial sum
//   shamt_i [SHAMT_WIDTH] arithmetic right-shift amount
//   data_o  [OUT_WIDTH]   signed requantized element
module pe_result_requant #(
  parameter int unsigned PSUM_WIDTH  = nmcu_pkg::PSUM_WIDTH,
  parameter int unsigned OUT_WIDTH   = nmcu_pkg::OUT_WIDTH,
  parameter int unsigned SHAMT_WIDTH = $clog2(PSUM_WIDTH)
) (
  input  logic [PSUM_WIDTH-1:0]  psum_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [OUT_WIDTH-1:0]   data_o
);

  localparam int unsigned EW = PSUM_WIDTH + 1;
  localparam longint SAT_MAX_L = (longint'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'(SAT_MAX_L);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-SAT_MAX_L - 1);

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shifted;
  logic signed [EW-1:0] clamped;

  always_comb begin
    ext = $signed({psum_i[PSUM_WIDTH-1], psum_i});
    rnd = '0;
    if (shamt_i != '0) begin
      rnd = $signed(EW'(1) << (shamt_i - SHAMT_WIDTH'(1)));
    end
    sum     = ext + rnd;
    shifted = sum >>> shamt_i;
`ifdef NMCU_RESULT_RELU_EN
    if (shifted[EW-1]) begin
      shifted = '0;
    end
`endif
    if (shifted > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = shifted;
    end
    data_o = OUT_WIDTH'(clamped);
  end

endmodule

// File: rtl/pe_result_drain.sv
// pe_result_drain: captures the PE array partial-sum matrix on the falling
// edge of pe_done_i, then streams it out one requantized row per beat over a
// valid/ready handshake. The capture bank lets the array start the next tile
// while the previous result drains.
// Option macro: NMCU_RESULT_RELU_EN (ReLU inside the requantizer).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pe_done_i         done level from the PE array; completion = falling edge
//   pe_result_i       live result matrix [PE_ROWS][PE_COLS] x PSUM_WIDTH
//   shamt_i           requant right shift, sampled at capture
//   out_valid_o/out_ready_i  row beat handshake
//   out_row_idx_o     current row index
//   out_data_o        requantized row [PE_COLS] x OUT_WIDTH
//   out_last_o        current beat is the final row
//   busy_o            bank holds undrained data
//   overrun_o         sticky: a completion arrived mid-drain and was dropped
//   clear_overrun_i   clears overrun_o (a same-cycle set wins)
module pe_result_drain
  import nmcu_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH  = nmcu_pkg::PSUM_WIDTH,
  parameter int unsigned OUT_WIDTH   = nmcu_pkg::OUT_WIDTH,
  parameter int unsigned PE_ROWS     = nmcu_pkg::PE_ROWS,
  parameter int unsigned PE_COLS     = nmcu_pkg::PE_COLS,
  parameter int unsigned SHAMT_WIDTH = $clog2(PSUM_WIDTH)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           pe_done_i,
  input  logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] pe_result_i,
  input  logic [SHAMT_WIDTH-1:0]                         shamt_i,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic [idx_width(PE_ROWS)-1:0]                  out_row_idx_o,
  output logic [PE_COLS-1:0][OUT_WIDTH-1:0]              out_data_o,
  output logic                                           out_last_o,
  output logic                                           busy_o,
  output logic                                           overrun_o,
  input  logic                                           clear_overrun_i
);

  localparam int unsigned ROW_W = idx_width(PE_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PE_ROWS - 1);

  drain_state_e                                   state_q;
  logic                                           done_q;
  logic [ROW_W-1:0]                               row_q;
  logic [SHAMT_WIDTH-1:0]                         shamt_q;
  logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] bank_q;
  logic                                           overrun_q;

  logic cpl_evt;
  logic beat_acc;
  logic last_acc;
  logic [PE_COLS-1:0][PSUM_WIDTH-1:0] row_sel;

  assign cpl_evt  = done_q & ~pe_done_i;
  assign beat_acc = (state_q == DRAIN_BUSY) & out_ready_i;
  assign last_acc = beat_acc & (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DRAIN_IDLE;
      done_q    <= 1'b0;
      row_q     <= '0;
      shamt_q   <= '0;
      bank_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= pe_done_i;
      unique case (state_q)
        DRAIN_IDLE: begin
          if (cpl_evt) begin
            bank_q  <= pe_result_i;
            shamt_q <= shamt_i;
            row_q   <= '0;
            state_q <= DRAIN_BUSY;
          end
        end
        DRAIN_BUSY: begin
          if (last_acc) begin
            row_q <= '0;
            // A completion landing on the final acceptance chains straight
            // into the next drain with no idle bubble.
            if (cpl_evt) begin
              bank_q  <= pe_result_i;
              shamt_q <= shamt_i;
            end else begin
              state_q <= DRAIN_IDLE;
            end
          end else if (beat_acc) begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        default: state_q <= DRAIN_IDLE;
      endcase
      if (cpl_evt && (state_q == DRAIN_BUSY) && !last_acc) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign row_sel = bank_q[row_q];

  for (genvar c = 0; c < PE_COLS; c++) begin : g_rq
    pe_result_requant #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_rq (
      .psum_i (row_sel[c]),
      .shamt_i(shamt_q),
      .data_o (out_data_o[c])
    );
  end

  assign out_valid_o   = (state_q == DRAIN_BUSY);
  assign busy_o        = (state_q == DRAIN_BUSY);
  assign out_row_idx_o = row_q;
  assign out_last_o    = out_valid_o & (row_q == LAST_ROW);
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain (4x4 array, 32-bit psums, 8-bit out).
// Stimulus pushes the expected row beats of every captured matrix; a monitor
// compares each presented beat with the queue head and pops on acceptance.
module tb_pe_result_drain;

  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned OW = 8;
  localparam int unsigned SW = 5;

  typedef logic [R-1:0][C-1:0][PW-1:0] mat_t;
  typedef logic [C-1:0][OW-1:0] row_t;
  typedef struct {
    int unsigned row;
    row_t        data;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pe_done_i = 1'b0;
  mat_t          pe_result_i = '0;
  logic [SW-1:0] shamt_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [1:0]    out_row_idx_o;
  row_t          out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          overrun_o;
  logic          clear_overrun_i = 1'b0;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  pe_result_drain #(
    .PSUM_WIDTH (PW),
    .OUT_WIDTH  (OW),
    .PE_ROWS    (R),
    .PE_COLS    (C),
    .SHAMT_WIDTH(SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pe_done_i      (pe_done_i),
    .pe_result_i    (pe_result_i),
    .shamt_i        (shamt_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_row_idx_o  (out_row_idx_o),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .clear_overrun_i(clear_overrun_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requant: round-half-up division by 2^sh, optional ReLU, clamp.
  function automatic logic [OW-1:0] model_rq(input longint x, input int sh);
    longint v, d, q;
    v = x + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
    d = longint'(1) << sh;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
`ifdef NMCU_RESULT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q[OW-1:0];
  endfunction

  task automatic push_matrix(input mat_t m, input int sh);
    beat_t b;
    for (int r = 0; r < R; r++) begin
      b.row = r;
      for (int c = 0; c < C; c++) b.data[c] = model_rq(longint'($signed(m[r][c])), sh);
      b.last = (r == R - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    int v;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        case ($urandom_range(0, 3))
          0: v = int'($urandom_range(0, 600)) - 300;
          1: v = int'($urandom);
          2: v = int'($urandom_range(0, 255)) - 128;
          default: v = ($urandom_range(0, 1) == 1) ? 32'sh7fff_ffff : 32'sh8000_0000;
        endcase
        m[r][c] = v;
      end
    end
    return m;
  endfunction

  // Holds done high for 'hold' cycles then drops it; returns #1 after the
  // capture edge, i.e. in the first beat cycle.
  task automatic capture(input mat_t m, input int sh, input int hold);
    pe_result_i = m;
    shamt_i     = SW'(sh);
    pe_done_i   = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    pe_done_i = 1'b0;
    push_matrix(m, sh);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit rnd_ready);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready_i = ($urandom_range(0, 3) != 0);
      if (exp_q.size() == 0 && !out_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready_i = 1'b1;
    check("drain_done", 64'(ok), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid_o), 0);
    check({tag, "_row"}, 64'(out_row_idx_o), 0);
    check({tag, "_data"}, 64'(out_data_o), 0);
    check({tag, "_last"}, 64'(out_last_o), 0);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_overrun"}, 64'(overrun_o), 0);
  endtask

  // Monitor: every presented beat must match the queue head; pop on accept.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst_n) begin
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: row %0d data %0h with empty queue", out_row_idx_o, out_data_o);
        end else begin
          b = exp_q[0];
          check("beat_row", 64'(out_row_idx_o), 64'(b.row));
          check("beat_data", 64'(out_data_o), 64'(b.data));
          check("beat_last", 64'(out_last_o), 64'(b.last));
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_last", 64'(out_last_o), 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    mat_t m, m2;
    int   sh, sh2;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic drain: identity values, shamt 0, ready high.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 32'(16 * r + c);
    capture(m, 0, 5);
    check("basic_valid_t1", 64'(out_valid_o), 1);
    check("basic_row_t1", 64'(out_row_idx_o), 0);
    check("basic_busy", 64'(busy_o), 1);
    repeat (R) @(posedge clk);
    #1;
    check("basic_valid_end", 64'(out_valid_o), 0);
    check("basic_busy_end", 64'(busy_o), 0);

    // Rounding, saturation and ReLU corner values.
    m = rand_mat();
    m[0][0] = 32'sd300;
    m[0][1] = -32'sd300;
    m[1][0] = -32'sd5;
    capture(m, 0, 2);
    wait_drain(1'b0);
    m = rand_mat();
    m[0][0] = 32'sd6;
    capture(m, 2, 1);
    wait_drain(1'b0);
    m = rand_mat();
    m[0][0] = 32'sd5;
    capture(m, 1, 3);
    wait_drain(1'b0);

    // Backpressure at row 1 for three cycles.
    capture(rand_mat(), int'($urandom_range(0, 31)), 2);
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_row_hold", 64'(out_row_idx_o), 1);
      check("bp_valid_hold", 64'(out_valid_o), 1);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    wait_drain(1'b0);

    // Overrun: second completion at row 1 is dropped.
    capture(rand_mat(), int'($urandom_range(0, 31)), 3);
    pe_result_i = rand_mat();
    pe_done_i   = 1'b1;
    @(posedge clk);
    #1;
    pe_done_i = 1'b0;
    check("ovr_pre", 64'(overrun_o), 0);
    @(posedge clk);
    #1;
    check("ovr_set", 64'(overrun_o), 1);
    check("ovr_row_advance", 64'(out_row_idx_o), 2);
    wait_drain(1'b0);
    check("ovr_sticky", 64'(overrun_o), 1);
    clear_overrun_i = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun_i = 1'b0;
    check("ovr_cleared", 64'(overrun_o), 0);

    // Set and clear in the same cycle: set wins.
    capture(rand_mat(), int'($urandom_range(0, 31)), 1);
    pe_done_i = 1'b1;
    @(posedge clk);
    #1;
    pe_done_i       = 1'b0;
    clear_overrun_i = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun_i = 1'b0;
    check("ovr_set_wins", 64'(overrun_o), 1);
    wait_drain(1'b0);
    clear_overrun_i = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun_i = 1'b0;
    check("ovr_cleared2", 64'(overrun_o), 0);

    // Back-to-back: completion coincides with row-3 acceptance.
    capture(rand_mat(), int'($urandom_range(0, 31)), 2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m2  = rand_mat();
    sh2 = int'($urandom_range(0, 31));
    pe_result_i = m2;
    shamt_i     = SW'(sh2);
    pe_done_i   = 1'b1;
    @(posedge clk);
    #1;
    pe_done_i = 1'b0;
    check("b2b_row3", 64'(out_row_idx_o), 3);
    push_matrix(m2, sh2);
    for (int k = 0; k < R; k++) begin
      @(posedge clk);
      #1;
      check("b2b_valid", 64'(out_valid_o), 1);
      check("b2b_row", 64'(out_row_idx_o), 64'(k));
    end
    @(posedge clk);
    #1;
    check("b2b_valid_end", 64'(out_valid_o), 0);
    check("b2b_overrun", 64'(overrun_o), 0);

    // Randomized tiles with random backpressure.
    for (int t = 0; t < 20; t++) begin
      sh = int'($urandom_range(0, 31));
      capture(rand_mat(), sh, int'($urandom_range(1, 4)));
      wait_drain(1'b1);
    end

    // Reset mid-drain abandons the bank.
    capture(rand_mat(), int'($urandom_range(0, 31)), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(out_valid_o), 0);

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream stage of the PE array interface. Captures the full PE_ROWS×PE_COLS partial-sum matrix when the array signals completion, requantizes each element (arithmetic shift, round, saturate), and streams the matrix out one row per beat over a valid/ready handshake toward the writeback path. The capture bank frees the PE array to start the next tile while the previous result drains.

## Interface
- PSUM_WIDTH, nmcu_pkg::PSUM_WIDTH: input element width, signed.
- OUT_WIDTH, nmcu_pkg::DATA_WIDTH: output element width, signed.
- PE_ROWS, nmcu_pkg::PE_ROWS: rows in the matrix, one beat per row.
- PE_COLS, nmcu_pkg::PE_COLS: elements per beat.
- SHAMT_WIDTH, $clog2(PSUM_WIDTH): width of the shift amount.

- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- pe_done_i  in  1  done level from the PE array interface; high while results are still settling.
- pe_result_i  in  PSUM_WIDTH × [PE_ROWS][PE_COLS]  live array result.
- shamt_i  in  SHAMT_WIDTH  right-shift amount, sampled at capture.
- out_valid_o  out  1  row beat valid.
- out_ready_i  in  1  downstream accepts beat.
- out_row_idx_o  out  $clog2(PE_ROWS) (min 1)  index of the current row.
- out_data_o  out  OUT_WIDTH × [PE_COLS]  requantized row.
- out_last_o  out  1  current beat is row PE_ROWS-1.
- busy_o  out  1  bank holds undrained data.
- overrun_o  out  1  sticky; a completion was dropped.
- clear_overrun_i  in  1  clears overrun_o.

## Operation
- done_q registers pe_done_i. Completion event = done_q & ~pe_done_i, the falling edge. Results are final in that cycle.
- States:
  - IDLE → DRAIN on a completion event. The bank loads pe_result_i and shamt_i, and row_idx is set to 0.
  - DRAIN: out_valid_o=1. On out_valid_o & out_ready_i, row_idx increments.
  - On acceptance of row PE_ROWS-1 → IDLE.
- Requant per element:
  - y = (x + (shamt>0 ? 1<<(shamt-1) : 0)) >>> shamt, with the add performed at PSUM_WIDTH+1 bits (no overflow).
  - Then saturate y to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1].
- out_data_o is combinational from bank row row_idx. It stays stable while out_valid_o & ~out_ready_i.
- Completion during DRAIN, not coinciding with the last-row acceptance: the event is dropped, overrun_o is set, and the bank is untouched.
- Completion in the same cycle as last-row acceptance: the new matrix is captured, the state stays DRAIN, row_idx=0, and there is no bubble.
- overrun set and clear_overrun_i in the same cycle: set wins.
- Reset mid-drain: the bank contents are abandoned and all state returns to IDLE.

## Timing
- Reset values: out_valid_o=0, out_row_idx_o=0, out_data_o=0, out_last_o=0, busy_o=0, overrun_o=0, done_q=0, bank=0.
- Completion detected in cycle T gives out_valid_o=1 with row 0 in cycle T+1. Capture latency is 1.
- With ready held high, the drain takes PE_ROWS cycles: rows 0..PE_ROWS-1 in T+1..T+PE_ROWS, and out_valid_o=0 at T+PE_ROWS+1.
- busy_o equals (state==DRAIN).
- out_last_o = out_valid_o & (row_idx==PE_ROWS-1).
- Throughput: one row per cycle. There is no combinational path from out_ready_i to out_valid_o.

## Configuration
- NMCU_RESULT_RELU_EN defined: after the shift and before saturation, negative y is clamped to 0. Outputs are then always in [0, 2^(OUT_WIDTH-1)-1].
- Undefined: signed passthrough; negative values are saturated only.

## Structure
- nmcu_pkg holds:
  - drain_state_e enum {DRAIN_IDLE, DRAIN_BUSY}.
  - OUT_WIDTH default constant.
  - SHAMT_WIDTH derivation.
- Sub-module pe_result_requant: one element, shift/round/saturate/optional ReLU. It is purely combinational and instantiated PE_COLS times on the selected bank row.

## Test plan
Bench config: PE_ROWS=PE_COLS=4, PSUM_WIDTH=32, OUT_WIDTH=8.
- Basic drain: pe_done_i high for 5 cycles then low, result[r][c]=16*r+c, shamt=0, ready=1 → 4 beats starting 1 cycle after the falling edge; row 2 = {32,33,34,35}; out_last_o on row 3 only.
- Rounding/saturation: element values 300, -300, 6 (shamt=2), 5 (shamt=1) → 127, -128, 2, 3.
- Backpressure: ready low for 3 cycles at row 1 → row 1 data and index held stable; 4 beats total in order.
- Overrun: second falling edge at row 1 of a drain → overrun_o=1 and the original data completes. After clear_overrun_i, overrun_o=0. Set and clear in the same cycle → overrun_o=1.
- Back-to-back: falling edge coincides with row-3 acceptance → next cycle row 0 of the new matrix, out_valid_o never drops.
- ReLU build: -5 with NMCU_RESULT_RELU_EN defined → 0; without → -5. rst_n asserted mid-drain → all outputs 0 immediately.
